n101_subsys_clic_irq_gate: RTL

- Receive-side gateway for the 32-bit CLIC interrupt vector driven by the subsystem interrupt allocation logic.
- Synchronises each line and detects level or rising edge per source. Latches edge pendings.
- Arbitrates the highest pending-and-enabled source and presents it to the core interrupt unit over a valid/ack handshake.
- Sits between the allocation wiring and the core CLIC interrupt entry.

---
 rtl/n101_subsys_clic_irq_gate.sv | 95 +++++++++
 1 files changed

// File: rtl/n101_subsys_clic_irq_gate.sv
// CLIC receive-side gateway: synchronises raw interrupt lines, latches edge
// pendings, and presents the highest-priority enabled source over valid/ack.
module n101_subsys_clic_irq_gate #(
  parameter int unsigned IRQ_NUM     = 32,
  parameter int unsigned ID_W        = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] clic_irq_i,
  input  logic [IRQ_NUM-1:0] cfg_ie,
  input  logic [IRQ_NUM-1:0] cfg_trig,
  input  logic               sw_clr_vld,
  input  logic [ID_W-1:0]    sw_clr_id,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  output logic [IRQ_NUM-1:0] irq_pend
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t             state_q, state_nxt;
  logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_NUM-1:0] s, h;
  logic [IRQ_NUM-1:0] edge_pend, edge_nxt, clr_mask, cand;
  logic [ID_W-1:0]    winner;
  logic               ack_acc, id_load;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      h <= '0;
    end else begin
      sync_q[0] <= clic_irq_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      h <= s;
    end
  end

  assign ack_acc = (state_q == REQ) && irq_ack;

  always_comb begin
    clr_mask = '0;
    if (ack_acc)    clr_mask[irq_id]    = 1'b1;
    if (sw_clr_vld) clr_mask[sw_clr_id] = 1'b1;
  end

  // A new edge overrides a same-cycle clear; masking with cfg_trig drops
  // latched pendings of sources switched to level mode.
  assign edge_nxt = ((edge_pend & ~clr_mask) | (s & ~h)) & cfg_trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_pend <= '0;
    else        edge_pend <= edge_nxt;
  end

  assign irq_pend = (edge_pend & cfg_trig) | (s & ~cfg_trig);
  assign cand     = irq_pend & cfg_ie;

  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < IRQ_NUM; i++)
      if (cand[i]) winner = ID_W'(i);
  end

  always_comb begin
    state_nxt = state_q;
    id_load   = 1'b0;
    case (state_q)
      IDLE: if (cand != '0) begin
        state_nxt = REQ;
        id_load   = 1'b1;
      end
      REQ:     if (irq_ack) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq_id  <= '0;
    end else begin
      state_q <= state_nxt;
      if (id_load) irq_id <= winner;
    end
  end

  assign irq_req = (state_q == REQ);

endmodule
